data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data-memory block RAM between the processor datapath
//  (load/store port) and an external loader/debug port. Arbitrates round-robin,
//  sequences each access through the RAM's fixed read latency, and returns read
//  data with a valid pulse. Sits between processor_top's LD/ST path and data_mem_gen.
// PARAMETERS
//  N        32  data word width
//  ADDR_W   7   word address width (matches data_mem_gen addra)
//  MEM_LAT  1   RAM read latency in clocks (>=1)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  cpu_req    in   1       CPU access request; held with fields stable until cpu_gnt
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU word address
//  cpu_wdata  in   N       CPU write data
//  cpu_gnt    out  1       1-cycle pulse: CPU access issued to RAM this cycle
//  cpu_rvalid out  1       1-cycle pulse: cpu_rdata holds new read data
//  cpu_rdata  out  N       CPU read data, held until next CPU read response
//  ext_req/ext_we/ext_addr/ext_wdata/ext_gnt/ext_rvalid/ext_rdata  same for ext port
//  mem_ena    out  1       RAM enable (ena)
//  mem_wea    out  1       RAM write enable (wea)
//  mem_addr   out  ADDR_W  RAM address
//  mem_din    out  N       RAM write data
//  mem_dout   in   N       RAM read data, valid MEM_LAT clocks after ena edge
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, all outputs 0, rdata regs 0, last_grant=EXT
//    (CPU wins first tie). Reset mid-access aborts it; no gnt/rvalid issued.
//  - FSM: IDLE -> ACCESS -> (read) WAIT -> RESP -> IDLE; (write) ACCESS -> IDLE.
//  - IDLE, cycle t: if any req, pick winner; register addr/wdata/we into mem_*;
//    go ACCESS. Neither req: stay IDLE, mem_ena=0.
//  - Arbitration: one requester -> it wins. Both -> the one NOT in last_grant;
//    last_grant updated on every grant.
//  - ACCESS, cycle t+1: mem_ena=1, mem_wea=we, winner gnt=1 (only cycle). Requester
//    must drop or change req by t+2; a req still high in IDLE is a new request.
//  - WAIT: MEM_LAT-1 cycles, counter from MEM_LAT-1 to 0 (MEM_LAT=1: zero cycles,
//    ACCESS goes straight to RESP). mem_ena=0 outside ACCESS.
//  - RESP, cycle t+1+MEM_LAT: capture mem_dout into winner rdata; rvalid=1 next
//    cycle (t+2+MEM_LAT) with state back in IDLE; other port's rdata untouched.
//  - Latency req->gnt: 1 clk if idle. Read req->rvalid: 2+MEM_LAT clks. Write
//    occupies 2 clks (IDLE+ACCESS), read 2+MEM_LAT clks.
//  - Requests arriving while busy are ignored until IDLE (no queueing);
//    requester keeps req high.
//  - Request dropped before gnt: no access, last_grant unchanged.
//  - gnt on both ports same cycle, or mem_wea=1 with mem_ena=0: never.
//  - Only one access in flight; no address range check (full ADDR_W space legal).
// TESTING
//  1 Reset then CPU write addr 0x05 data 0xDEADBEEF -> cpu_gnt at t+1, mem_ena=1,
//    mem_wea=1, mem_addr=0x05, mem_din=0xDEADBEEF; busy 0 at t+2.
//  2 CPU read 0x05 after test 1 (MEM_LAT=1) -> cpu_rvalid at t+3,
//    cpu_rdata=0xDEADBEEF; ext_rvalid stays 0.
//  3 Both req same cycle after reset -> CPU granted first, ext next pass;
//    repeat with both held -> grants alternate CPU,EXT,CPU,EXT.
//  4 MEM_LAT=3, ext read 0x7F holding 0x12345678 -> ext_rvalid at t+5 with
//    0x12345678; mem_ena high only in t+1.
//  5 Assert rst during WAIT of a read -> outputs 0 immediately, no rvalid;
//    after release CPU read of same addr completes normally.
//  6 ext_req pulsed during CPU read then dropped before IDLE -> no ext_gnt,
//    no RAM access, last_grant stays CPU.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU load/store
// path and the external loader/debug port; one access in flight at a time.
module data_mem_arbiter #(
  parameter int N       = 32,
  parameter int ADDR_W  = 7,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [N-1:0]      cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [N-1:0]      cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [N-1:0]      ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [N-1:0]      ext_rdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_din,
  input  logic [N-1:0]      mem_dout,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req with stable fields until its 1-cycle gnt pulse,
  // then drops or changes req within one cycle; reads answer with a 1-cycle rvalid
  // and rdata holds until that port's next read response. No queueing while busy.

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_ext_q;
  logic              own_ext_q;
  logic              we_q;
  logic              cpu_gnt_q, ext_gnt_q;
  logic              cpu_rvalid_q, ext_rvalid_q;
  logic [N-1:0]      cpu_rdata_q, ext_rdata_q;
  logic              mem_ena_q, mem_wea_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [N-1:0]      mem_din_q;

  logic sel_cpu;
  logic any_req;

  // On a tie the port that did not win last time goes first.
  assign sel_cpu = cpu_req && (!ext_req || last_ext_q);
  assign any_req = cpu_req || ext_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_ext_q   <= 1'b1;
      own_ext_q    <= 1'b0;
      we_q         <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      mem_ena_q    <= 1'b0;
      mem_wea_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      mem_ena_q    <= 1'b0;
      mem_wea_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q    <= S_ACCESS;
            own_ext_q  <= !sel_cpu;
            last_ext_q <= !sel_cpu;
            we_q       <= sel_cpu ? cpu_we    : ext_we;
            mem_addr_q <= sel_cpu ? cpu_addr  : ext_addr;
            mem_din_q  <= sel_cpu ? cpu_wdata : ext_wdata;
            mem_ena_q  <= 1'b1;
            mem_wea_q  <= sel_cpu ? cpu_we    : ext_we;
            cpu_gnt_q  <= sel_cpu;
            ext_gnt_q  <= !sel_cpu;
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            state_q <= S_IDLE;
          end else if (MEM_LAT == 1) begin
            state_q <= S_RESP;
          end else begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (own_ext_q) begin
            ext_rdata_q  <= mem_dout;
            ext_rvalid_q <= 1'b1;
          end else begin
            cpu_rdata_q  <= mem_dout;
            cpu_rvalid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign ext_gnt    = ext_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ext_rdata  = ext_rdata_q;
  assign mem_ena    = mem_ena_q;
  assign mem_wea    = mem_wea_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule
